// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and constants for the ADC capture block.
// Holds the capture FSM state encoding, the buffer depth helper and the
// offset-binary midscale code used to preload the input pipeline.
package adc_capture_pkg;

  // Capture sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Offset-binary midscale for a 12-bit converter (zero-volt input code)
  localparam logic [11:0] ADC_MIDSCALE = 12'h800;

  // Ring buffer depth for a given address width
  function automatic int depth_of(input int addr_w);
    return int'(32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample RAM for adc_capture.
// One write port and one registered read port with one-cycle latency.
// A read of the address being written in the same cycle returns the old word.
module capture_ram
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Sample storage: contents are not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; output holds while no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_capture.sv
// adc_capture: parallel ADC acquisition with pre/post-trigger ring buffer.
// Drives the ADC sample clock, registers the ADC bus and records one
// DEPTH-sample record around a level/slope or forced trigger.
// Optional feature macro: ADC_CAPTURE_DECIM_EN adds the decim input and a
// keep-one-in-(decim+1) sample divider.
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int ADDR_W    = 10,
  parameter int PRE_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              AD_CLK,
  input  logic [DATA_W-1:0] AD_DATA,
  input  logic              AD_OTR,
  input  logic              arm,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_slope,
`ifdef ADC_CAPTURE_DECIM_EN
  input  logic [7:0]        decim,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              ovr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH    = depth_of(ADDR_W);
  localparam int POST_LEN = DEPTH - PRE_DEPTH - 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_DEPTH - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] s1_q, s2_q;
  logic              otr1_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              keep_s;
  logic              wr_en_s;
  logic              rise_s, fall_s, edge_s;

  // ADC samples on the opposite clock phase so data is stable at our edge
  assign AD_CLK = ~clk;

`ifdef ADC_CAPTURE_DECIM_EN
  logic [7:0] dcnt_q, dcnt_d;

  assign keep_s = (dcnt_q == 8'd0);

  // Decimation divider: restarts on arm so the first PRE sample is kept
  always_comb begin
    dcnt_d = dcnt_q;
    if ((state_q == ST_IDLE || state_q == ST_DONE) && arm) begin
      dcnt_d = 8'd0;
    end else if (state_q == ST_PRE || state_q == ST_ARMED || state_q == ST_POST) begin
      dcnt_d = keep_s ? decim : (dcnt_q - 8'd1);
    end else begin
      dcnt_d = dcnt_q;
    end
  end

  // Decimation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= 8'd0;
    end else begin
      dcnt_q <= dcnt_d;
    end
  end
`else
  assign keep_s = 1'b1;
`endif

  // Input pipeline: s1 is the sample being written, s2 the previous kept one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= DATA_W'(ADC_MIDSCALE);
      s2_q   <= DATA_W'(ADC_MIDSCALE);
      otr1_q <= 1'b0;
    end else begin
      s1_q   <= AD_DATA;
      otr1_q <= AD_OTR;
      if (keep_s) begin
        s2_q <= s1_q;
      end else begin
        s2_q <= s2_q;
      end
    end
  end

  assign rise_s = (s2_q < trig_level) && (s1_q >= trig_level);
  assign fall_s = (s2_q > trig_level) && (s1_q <= trig_level);
  assign edge_s = trig_slope ? rise_s : fall_s;

  // Capture sequencer: next state, write strobe, pointers and status
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    ovr_d       = ovr_q;
    wr_en_s     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d  = ST_PRE;
          wr_ptr_d = {ADDR_W{1'b0}};
          cnt_d    = {ADDR_W{1'b0}};
          ovr_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_PRE: begin
        if (keep_s) begin
          wr_en_s = 1'b1;
          if (cnt_q == PRE_LAST) begin
            state_d = ST_ARMED;
            cnt_d   = {ADDR_W{1'b0}};
          end else begin
            cnt_d = cnt_q + ADDR_ONE;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_ARMED: begin
        if (keep_s) begin
          wr_en_s = 1'b1;
          if (edge_s || force_trig) begin
            state_d     = ST_POST;
            trig_addr_d = wr_ptr_q;
            cnt_d       = {ADDR_W{1'b0}};
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_POST: begin
        if (keep_s) begin
          wr_en_s = 1'b1;
          if (cnt_q == POST_LAST) begin
            state_d = ST_DONE;
            cnt_d   = {ADDR_W{1'b0}};
          end else begin
            cnt_d = cnt_q + ADDR_ONE;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_ONE;
      ovr_d    = ovr_q | otr1_q;
    end else begin
      wr_ptr_d = wr_ptr_d;
    end

    busy_d = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
    done_d = (state_d == ST_DONE);
  end

  // Sequencer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {ADDR_W{1'b0}};
      cnt_q       <= {ADDR_W{1'b0}};
      trig_addr_q <= {ADDR_W{1'b0}};
      ovr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      ovr_q       <= ovr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_addr = trig_addr_q;
  assign ovr       = ovr_q;

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (s1_q),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: self-checking bench for adc_capture.
// Each capture logs the samples driven since arm; a reference model picks the
// trigger sample from the level/slope/force rules, predicts done timing,
// trig_addr and ovr, and rebuilds the expected ring contents for readback.
module tb_adc_capture;

  localparam int DATA_W    = 12;
  localparam int ADDR_W    = 10;
  localparam int PRE_DEPTH = 256;
  localparam int DEPTH     = 1024;
  localparam int POST_LEN  = DEPTH - PRE_DEPTH - 1;
  localparam int MAXC      = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              AD_CLK;
  logic [DATA_W-1:0] AD_DATA = '0;
  logic              AD_OTR = 1'b0;
  logic              arm = 1'b0;
  logic              force_trig = 1'b0;
  logic [DATA_W-1:0] trig_level = '0;
  logic              trig_slope = 1'b1;
  logic              busy, done, ovr;
  logic [ADDR_W-1:0] trig_addr;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  int drv   [MAXC];
  bit frc   [MAXC];
  bit otr_a [MAXC];
  int model_mem [DEPTH];

  adc_capture #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PRE_DEPTH(PRE_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AD_CLK     (AD_CLK),
    .AD_DATA    (AD_DATA),
    .AD_OTR     (AD_OTR),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
`ifdef ADC_CAPTURE_DECIM_EN
    .decim      (8'd0),
`endif
    .busy       (busy),
    .done       (done),
    .trig_addr  (trig_addr),
    .ovr        (ovr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit edge_hit(input int prev, input int cur, input int lvl, input bit slope);
    if (slope) return (prev < lvl) && (cur >= lvl);
    else       return (prev > lvl) && (cur <= lvl);
  endfunction

  // Modes: 0 rise step, 1 fall step, 2 rise step with falling slope + force,
  // 3 early step + force, 4 step + otr/arm during POST, 5 random, 6 reset in POST
  task automatic run_capture(input int mode, output int k_trig);
    int lvl;
    bit slope;
    bit ovr_exp;
    bit finished;
    k_trig   = -1;
    finished = 1'b0;
    ovr_exp  = 1'b0;
    case (mode)
      1, 2:    begin lvl = 1000; slope = 1'b0; end
      5:       begin lvl = int'($urandom_range(1, 4094)); slope = 1'($urandom_range(0, 1)); end
      default: begin lvl = 1000; slope = 1'b1; end
    endcase
    trig_level = DATA_W'(lvl);
    trig_slope = slope;
    for (int j = 0; j < MAXC; j++) begin
      @(posedge clk); #1;
      case (mode)
        1:       drv[j] = (j < 400) ? 3000 : 500;
        2:       drv[j] = (j < 400) ? 500 : 3000;
        3:       drv[j] = (j < 100) ? 0 : 2000;
        5:       drv[j] = int'($urandom_range(0, 4095));
        default: drv[j] = (j < 400) ? 0 : 2000;
      endcase
      frc[j]   = (mode == 2 && j == 700) || (mode == 3 && j == 600) ||
                 (mode == 5 && ($urandom_range(0, 299) == 0 || j == 2000));
      otr_a[j] = (mode == 4 && k_trig >= 0 && j == k_trig + 50) ||
                 (mode == 5 && $urandom_range(0, 199) == 0);
      arm        = (j == 0) || (mode == 4 && k_trig >= 0 && j == k_trig + 300);
      AD_DATA    = DATA_W'(drv[j]);
      force_trig = frc[j];
      AD_OTR     = otr_a[j];
      if (k_trig < 0 && j - 1 >= PRE_DEPTH) begin
        if (edge_hit(drv[j-2], drv[j-1], lvl, slope) || frc[j]) k_trig = j - 1;
      end
      @(negedge clk);
      if (j == 1) begin
        check_eq("busy_after_arm", busy, 1);
        check_eq("done_after_arm", done, 0);
        check_eq("ovr_cleared_by_arm", ovr, 0);
      end
      if (mode == 6 && k_trig >= 0 && j == k_trig + 100) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_trig_addr", trig_addr, 0);
        arm = 1'b0; force_trig = 1'b0; AD_OTR = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      if (k_trig >= 0 && j == k_trig + POST_LEN + 1) begin
        check_eq("done_before_last", done, 0);
        check_eq("busy_before_last", busy, 1);
      end
      if (k_trig >= 0 && j == k_trig + POST_LEN + 2) begin
        for (int m = 0; m <= k_trig + POST_LEN; m++) ovr_exp |= otr_a[m];
        check_eq("done_rise", done, 1);
        check_eq("busy_fall", busy, 0);
        check_eq("trig_addr", trig_addr, k_trig % DEPTH);
        check_eq("ovr_sticky", ovr, ovr_exp);
        finished = 1'b1;
        break;
      end
    end
    arm = 1'b0; force_trig = 1'b0; AD_OTR = 1'b0;
    if (!finished) check_eq("capture_timeout", 0, 1);
  endtask

  // Read the whole ring back and compare with the rebuilt record
  task automatic check_record(input int k_trig);
    if (k_trig < 0) return;
    for (int m = 0; m <= k_trig + POST_LEN; m++) model_mem[m % DEPTH] = drv[m];
    for (int a = 0; a < DEPTH; a++) begin
      @(posedge clk); #1;
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(a);
      AD_DATA = DATA_W'($urandom_range(0, 4095));
      @(posedge clk); #1;
      rd_en = 1'b0;
      check_eq($sformatf("rec[%0d]", a), rd_data, model_mem[a]);
    end
    rd_addr = ADDR_W'(0);
    @(posedge clk); #1;
    check_eq("rd_hold", rd_data, model_mem[DEPTH-1]);
  endtask

  initial begin
    int kt;
    bit exp_clk;
    // Reset behaviour
    repeat (3) begin
      @(negedge clk);
      exp_clk = !clk;
      check_eq("rst_ad_clk_low_phase", AD_CLK, exp_clk);
    end
    check_eq("rst_busy0", busy, 0);
    check_eq("rst_done0", done, 0);
    check_eq("rst_trig0", trig_addr, 0);
    check_eq("rst_ovr0", ovr, 0);
    check_eq("rst_rd0", rd_data, 0);
    @(posedge clk); #1;
    exp_clk = !clk;
    check_eq("rst_ad_clk_high_phase", AD_CLK, exp_clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_done", done, 0);

    run_capture(0, kt); check_record(kt);
    check_eq("rise_trig_index", kt, 400);
    run_capture(1, kt); check_record(kt);
    check_eq("fall_trig_index", kt, 400);
    run_capture(2, kt); check_record(kt);
    check_eq("wrong_slope_force_index", kt, 699);
    run_capture(3, kt); check_record(kt);
    check_eq("early_edge_force_index", kt, 599);
    run_capture(4, kt); check_record(kt);
    run_capture(5, kt); check_record(kt);
    run_capture(5, kt); check_record(kt);
    run_capture(6, kt);
    @(negedge clk);
    check_eq("post_rst_busy", busy, 0);
    run_capture(0, kt); check_record(kt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
# adc_capture

Parallel-ADC acquisition block: the receive-side counterpart of the DDS/DAC output path. It drives the ADC sample clock, registers the 12-bit ADC bus, and runs a pre/post-trigger capture into an on-chip ring buffer. A host-side reader fetches the captured record through a synchronous read port. It sits between the ADC pins and the measurement/readback logic, on the same system clock as the DAC path.

## Interface
- DATA_W, 12: ADC sample width, offset-binary.
- ADDR_W, 10: buffer address width; DEPTH = 2^ADDR_W.
- PRE_DEPTH, 256: samples kept before the trigger; legal range 1..DEPTH-2.

- clk  in  1  system/sample clock.
- rst_n  in  1  asynchronous, active-low reset.
- AD_CLK  out  1  ADC sample clock = ~clk, combinational, toggles during reset too.
- AD_DATA  in  DATA_W  ADC output bus.
- AD_OTR  in  1  ADC out-of-range flag.
- arm  in  1  single-cycle pulse: start a capture.
- force_trig  in  1  trigger immediately when in ARMED.
- trig_level  in  DATA_W  threshold, unsigned offset-binary compare.
- trig_slope  in  1  1 = rising, 0 = falling.
- busy  out  1  high in PRE, ARMED, POST.
- done  out  1  high in DONE.
- trig_addr  out  ADDR_W  buffer address holding the trigger sample.
- ovr  out  1  sticky: AD_OTR seen on any written sample since last arm.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data.

## Operation
- Input pipeline: s1 <= AD_DATA, s2 <= s1; s1 written to buffer at wr_ptr; s2 is the previous sample for edge detection.
- Rising trigger: s2 < trig_level && s1 >= trig_level. Falling: s2 > trig_level && s1 <= trig_level.
- States: IDLE, PRE, ARMED, POST, DONE.
- IDLE/DONE: no writes. arm -> PRE; wr_ptr, pre counter and ovr cleared; done drops.
- PRE: write every cycle; after PRE_DEPTH writes -> ARMED. Edges during PRE ignored.
- ARMED: write every cycle; on edge or force_trig, trig_addr <= wr_ptr of that sample -> POST.
- POST: write DEPTH-PRE_DEPTH-1 more samples, then -> DONE.
- wr_ptr increments modulo DEPTH; oldest record sample at (trig_addr-PRE_DEPTH) mod DEPTH.
- arm in PRE/ARMED/POST is ignored. force_trig outside ARMED is ignored.
- Edge and force_trig in the same cycle: single trigger, same sample.
- Read port active in every state; same-address read/write returns old data.

## Timing
- Reset values: busy 0, done 0, trig_addr 0, ovr 0, rd_data 0, state IDLE, pointers 0.
- AD_DATA at edge n is written to the buffer at edge n+2.
- Trigger decision and trig_addr update in the same cycle as the trigger sample write.
- done rises the cycle after the last POST write; busy falls in the same cycle.
- rd_data valid one cycle after rd_en; held when rd_en low.
- Reset asserted mid-capture: immediate return to IDLE, done 0; buffer contents undefined.

## Configuration
- ADC_CAPTURE_DECIM_EN defined: adds port decim in 8, plus a divide counter. A sample is kept once every decim+1 cycles (decim = 0 keeps every cycle). Writes, pre/post counts, edge detection and ovr apply to kept samples only. s2 holds the previous kept sample. The counter restarts on arm.
- Undefined: no decim port; every cycle's sample is kept.

## Structure
- Package adc_capture_pkg: state enum, DEPTH localparam derivation helper, offset-binary midscale constant.
- Sub-module capture_ram: simple dual-port RAM, one write port, registered read port with one-cycle latency.

## Test plan
- Reset: rst_n low -> all outputs 0, AD_CLK = ~clk; after release state IDLE, no buffer writes.
- Rising step: arm, AD_DATA = 0 for 400 cycles then 2000, level 1000 -> trigger on the step; buffer[trig_addr] = 2000, buffer[trig_addr-1] = 0; done after 767 further writes; busy 0.
- Falling slope: trig_slope 0, AD_DATA 3000 -> 500, level 1000 -> trigger at the first 500 sample; a rising step with the same settings gives no trigger.
- Early edge: step at cycle 100 after arm (inside PRE) -> no trigger; flat input then force_trig -> trigger on the current sample, done 768 writes later.
- Overrange: AD_OTR pulsed during POST -> ovr 1 through DONE; next arm clears ovr. arm during POST is ignored.
- Mid-capture reset: rst_n low in POST -> busy 0, done 0 immediately; re-arm after release runs a full capture correctly.
